vc_buf4: RTL and testbench

Per-port input virtual-channel buffer that feeds the 4-to-1 VC arbiter. It accepts flits and their injection timestamps from the upstream link and places each one in the lowest-index VC that has space. It presents each VC's head timestamp on `time_out_0..3` for arbitration, and dequeues the granted VC's head flit into a registered output. One instance sits in front of each router input port's VC arbiter.

---
 rtl/vc_buf4_if.sv | 31 +++
 rtl/vc_buf4.sv | 76 +++++++
 tb/tb_vc_buf4.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vc_buf4_if.sv
// vc_buf4_if: upstream flit/timestamp link, arbiter-facing head timestamps and dequeue port of vc_buf4
//   master: upstream + arbiter side (drives in_valid/in_data/in_time, deq_en/deq_vc)
//   slave : vc_buf4 side (drives in_ready, time_out_0..3, vc_nempty, flit_out, flit_out_valid, deq_err)
interface vc_buf4_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TIME_WIDTH = 8,
  parameter int VC_INDEX_WIDTH = 2
);
  logic in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [TIME_WIDTH-1:0] in_time;
  logic in_ready;
  logic [TIME_WIDTH-1:0] time_out_0;
  logic [TIME_WIDTH-1:0] time_out_1;
  logic [TIME_WIDTH-1:0] time_out_2;
  logic [TIME_WIDTH-1:0] time_out_3;
  logic [3:0] vc_nempty;
  logic deq_en;
  logic [VC_INDEX_WIDTH-1:0] deq_vc;
  logic [DATA_WIDTH-1:0] flit_out;
  logic flit_out_valid;
  logic deq_err;
  modport master (
    output in_valid, in_data, in_time, deq_en, deq_vc,
    input in_ready, time_out_0, time_out_1, time_out_2, time_out_3, vc_nempty, flit_out, flit_out_valid, deq_err
  );
  modport slave (
    input in_valid, in_data, in_time, deq_en, deq_vc,
    output in_ready, time_out_0, time_out_1, time_out_2, time_out_3, vc_nempty, flit_out, flit_out_valid, deq_err
  );
endinterface

// File: rtl/vc_buf4.sv
// vc_buf4: 4-VC input buffer; enqueues into lowest non-full VC, exposes head timestamps, dequeues granted VC
//   clk, rst_n (async active-low) plain ports; bus (vc_buf4_if.slave) carries enqueue link,
//   head timestamps time_out_0..3, vc_nempty, and the dequeue request / registered flit_out, flit_out_valid, deq_err
module vc_buf4 #(
  parameter int DATA_WIDTH = 64,
  parameter int TIME_WIDTH = 8,
  parameter int VC_INDEX_WIDTH = 2,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  vc_buf4_if.slave bus
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem_d [4][DEPTH];
  logic [TIME_WIDTH-1:0] mem_t [4][DEPTH];
  logic [PW-1:0] rptr [4];
  logic [PW-1:0] wptr [4];
  logic [OW-1:0] occ [4];
  logic [TIME_WIDTH-1:0] head_t [4];
  logic [3:0] nempty, full, enq, deq;
  logic [TIME_WIDTH-1:0] t_in;
  logic deq_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nempty[i] = occ[i] != '0;
      full[i] = occ[i] == OW'(DEPTH);
      head_t[i] = nempty[i] ? mem_t[i][rptr[i]] : '1;
    end
    // ~full & (full + 1) isolates the lowest non-full VC
    enq = {4{bus.in_valid}} & ~full & (full + 4'd1);
    deq_ok = bus.deq_en && nempty[bus.deq_vc];
    deq = 4'(deq_ok) << bus.deq_vc;
    // all-ones is reserved as the empty marker on time_out_*
    t_in = &bus.in_time ? bus.in_time - 1'b1 : bus.in_time;
  end
  assign bus.in_ready = ~&full;
  assign bus.vc_nempty = nempty;
  assign bus.time_out_0 = head_t[0];
  assign bus.time_out_1 = head_t[1];
  assign bus.time_out_2 = head_t[2];
  assign bus.time_out_3 = head_t[3];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (enq[i]) begin
        mem_d[i][wptr[i]] <= bus.in_data;
        mem_t[i][wptr[i]] <= t_in;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rptr[i] <= '0;
        wptr[i] <= '0;
        occ[i] <= '0;
      end
      bus.flit_out <= '0;
      bus.flit_out_valid <= 1'b0;
      bus.deq_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (enq[i]) wptr[i] <= nxt(wptr[i]);
        if (deq[i]) rptr[i] <= nxt(rptr[i]);
        occ[i] <= occ[i] + OW'(enq[i]) - OW'(deq[i]);
      end
      bus.flit_out_valid <= deq_ok;
      bus.deq_err <= bus.deq_en && !deq_ok;
      if (deq_ok) bus.flit_out <= mem_d[bus.deq_vc][rptr[bus.deq_vc]];
    end
  end
endmodule

// File: tb/tb_vc_buf4.sv
// tb_vc_buf4: directed scoreboard bench for vc_buf4 (DEPTH=2)
module tb_vc_buf4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int err = 0;
  logic [63:0] sb [$];
  vc_buf4_if #(.DATA_WIDTH(64), .TIME_WIDTH(8), .VC_INDEX_WIDTH(2)) b ();
  vc_buf4 #(.DATA_WIDTH(64), .TIME_WIDTH(8), .VC_INDEX_WIDTH(2), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] d(input int n);
    return 64'hC0DE_0000_0000_0000 | 64'(n);
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [7:0] t, input logic [63:0] v);
    b.in_valid = 1'b1;
    b.in_time = t;
    b.in_data = v;
    step();
    b.in_valid = 1'b0;
  endtask
  task automatic deq(input logic [1:0] vc, input logic [63:0] e);
    sb.push_back(e);
    b.deq_en = 1'b1;
    b.deq_vc = vc;
    step();
    b.deq_en = 1'b0;
    chk("deq_valid", b.flit_out_valid, 1);
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_ready"}, b.in_ready, 1);
    chk({n, "_t0"}, b.time_out_0, 8'hFF);
    chk({n, "_t1"}, b.time_out_1, 8'hFF);
    chk({n, "_t2"}, b.time_out_2, 8'hFF);
    chk({n, "_t3"}, b.time_out_3, 8'hFF);
    chk({n, "_nempty"}, b.vc_nempty, 0);
    chk({n, "_flit"}, b.flit_out, 0);
    chk({n, "_valid"}, b.flit_out_valid, 0);
    chk({n, "_err"}, b.deq_err, 0);
  endtask
  always @(negedge clk) begin
    if (rst_n && b.flit_out_valid) begin
      if (sb.size() == 0) chk("unexpected_flit", b.flit_out, 64'hX);
      else chk("flit_out", b.flit_out, sb.pop_front());
    end
  end
  initial begin
    b.in_valid = 1'b0;
    b.in_data = '0;
    b.in_time = '0;
    b.deq_en = 1'b0;
    b.deq_vc = '0;
    step();
    step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();
    enq(8'd5, d(5));
    enq(8'd6, d(6));
    enq(8'd7, d(7));
    chk("t0_5", b.time_out_0, 8'd5);
    chk("t1_7", b.time_out_1, 8'd7);
    chk("t2_empty", b.time_out_2, 8'hFF);
    chk("t3_empty", b.time_out_3, 8'hFF);
    chk("nempty_3", b.vc_nempty, 4'b0011);
    chk("ready_partial", b.in_ready, 1);
    for (int i = 8; i <= 12; i++) enq(8'(i), d(i));
    chk("ready_full", b.in_ready, 0);
    chk("nempty_full", b.vc_nempty, 4'b1111);
    chk("t2_9", b.time_out_2, 8'd9);
    chk("t3_11", b.time_out_3, 8'd11);
    b.in_valid = 1'b1;
    b.in_time = 8'd13;
    b.in_data = d(13);
    step();
    chk("hold_ready", b.in_ready, 0);
    chk("hold_t2", b.time_out_2, 8'd9);
    sb.push_back(d(9));
    b.deq_en = 1'b1;
    b.deq_vc = 2'd2;
    step();
    b.deq_en = 1'b0;
    chk("deq2_valid", b.flit_out_valid, 1);
    chk("deq2_ready", b.in_ready, 1);
    chk("deq2_t2", b.time_out_2, 8'd10);
    step();
    b.in_valid = 1'b0;
    chk("refill_ready", b.in_ready, 0);
    chk("refill_t2", b.time_out_2, 8'd10);
    chk("pulse_one_cycle", b.flit_out_valid, 0);
    deq(2'd2, d(10));
    chk("ninth_in_vc2", b.time_out_2, 8'd13);
    deq(2'd0, d(5));
    chk("t0_6", b.time_out_0, 8'd6);
    deq(2'd0, d(6));
    chk("t0_drained", b.time_out_0, 8'hFF);
    chk("nempty_e", b.vc_nempty, 4'b1110);
    step();
    chk("idle_valid", b.flit_out_valid, 0);
    deq(2'd3, d(11));
    deq(2'd3, d(12));
    chk("nempty_6", b.vc_nempty, 4'b0110);
    b.deq_en = 1'b1;
    b.deq_vc = 2'd3;
    step();
    b.deq_en = 1'b0;
    chk("empty_err", b.deq_err, 1);
    chk("empty_valid", b.flit_out_valid, 0);
    chk("empty_flit_hold", b.flit_out, d(12));
    chk("empty_nempty", b.vc_nempty, 4'b0110);
    step();
    chk("err_one_cycle", b.deq_err, 0);
    enq(8'hFF, d(255));
    chk("sat_fe", b.time_out_0, 8'hFE);
    b.in_valid = 1'b1;
    b.in_time = 8'd20;
    b.in_data = d(20);
    sb.push_back(d(255));
    b.deq_en = 1'b1;
    b.deq_vc = 2'd0;
    step();
    b.in_valid = 1'b0;
    b.deq_en = 1'b0;
    chk("conc_valid", b.flit_out_valid, 1);
    chk("conc_nempty", b.vc_nempty, 4'b0111);
    chk("conc_t0", b.time_out_0, 8'd20);
    deq(2'd0, d(20));
    chk("conc_occ1", b.time_out_0, 8'hFF);
    chk("conc_nempty_after", b.vc_nempty, 4'b0110);
    b.in_valid = 1'b1;
    b.in_time = 8'd30;
    b.in_data = d(30);
    b.deq_en = 1'b1;
    b.deq_vc = 2'd0;
    step();
    b.in_valid = 1'b0;
    b.deq_en = 1'b0;
    chk("enq_empty_err", b.deq_err, 1);
    chk("enq_empty_valid", b.flit_out_valid, 0);
    chk("enq_empty_t0", b.time_out_0, 8'd30);
    chk("enq_empty_nempty", b.vc_nempty, 4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    #2;
    rst_n = 1'b1;
    step();
    enq(8'h40, d(64));
    chk("post_rst_t0", b.time_out_0, 8'h40);
    chk("post_rst_nempty", b.vc_nempty, 4'b0001);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
